dual_bus_req_ack_ctrl: RTL and testbench
========================================

// Module: dual_bus_req_ack_ctrl
// PURPOSE
//  Front-end controller for a shared bus that has two requester channels (req1/ack1, req2/ack2).
//  Only the channel selected by bus_select==bus1 (channel 1) or bus_select!=bus1 (channel 2) is served.
//  Each request is sequenced onto one downstream bus port, and ack is guaranteed 1..ACK_WIN+1 cycles after $rose(req).
//  A power-on holdoff of HOLDOFF_CYCLES clocks is applied before any request is honoured.
// PARAMETERS
//  HOLDOFF_CYCLES  500  clocks after reset release during which requests are ignored
//  ACK_WIN         5    ack lands at ##[0:ACK_WIN] after the cycle following $rose(req); range 2..15
// PORTS
//  clk          in   1  clock; all logic on posedge
//  reset        in   1  synchronous, active-high reset
//  bus_select   in   1  live bus selector
//  bus1         in   1  selector value meaning "channel 1 active"
//  req1, req2   in   1  level requests from channels 1/2
//  ack1, ack2   out  1  one-cycle completion pulses to channels 1/2
//  bus_req      out  1  request to downstream bus; level, held until done or timeout
//  bus_chan     out  1  0=channel 1, 1=channel 2; valid while bus_req=1
//  bus_done     in   1  downstream completion; sampled only while bus_req=1
//  ready        out  1  holdoff expired
//  timeout_err  out  1  one-cycle pulse: ack forced without bus_done
//  overrun_err  out  1  one-cycle pulse: $rose on the active channel while busy (dropped)
// BEHAVIOUR
//  Reset: every output is 0, the state is HOLD, the holdoff counter is 0, and req1_q/req2_q are 0.
//  Reset asserted mid-operation aborts the transaction. No ack is issued for it.
//  Edge detect: reqN_q registers reqN every cycle, including HOLD. rose_N = reqN & ~reqN_q.
//  Active channel: act = (bus_select==bus1) ? 1 : 2. It is evaluated each cycle and latched at accept.
//  States:
//   HOLD: counter increments each cycle. At count==HOLDOFF_CYCLES-1, go to IDLE and set ready=1 next cycle.
//    Edges seen in HOLD are ignored, so the first serviceable edge is at cycle >= HOLDOFF_CYCLES.
//   IDLE: if rose_act at cycle T, latch chan=act, clear the wait counter, and go to BUSY.
//    rose on the inactive channel is ignored and has no error.
//   BUSY (from T+1): bus_req=1 and bus_chan=chan. The wait counter increments each cycle.
//    bus_done=1 at cycle T+k (1<=k<=ACK_WIN): go to DONE. That channel's ack is high at T+k+1.
//    No done by T+ACK_WIN: at T+ACK_WIN+1 bus_req drops, ack(chan)=1 and timeout_err=1.
//    Late bus_done is ignored.
//   DONE: ack(chan)=1 for exactly one cycle, bus_req=0, then go to IDLE.
//    A rose_act in the DONE cycle is accepted as a new T.
//  The ack window always holds: ack at T+1..T+ACK_WIN+1. ack1 and ack2 are never high together.
//  The inactive channel's ack stays 0.
//  A bus_select change during BUSY/DONE does not retarget the transaction; it completes on the latched chan.
//  rose on the latched channel during BUSY: drop it and pulse overrun_err.
//   rose on the other channel during BUSY is ignored.
//  Simultaneous rose_1 and rose_2: only the act channel is accepted.
//  bus_done while bus_req=0: ignored.
//  Wait counter width: $clog2(ACK_WIN+2) bits. It saturates; it never wraps.
//  Holdoff counter width: $clog2(HOLDOFF_CYCLES+1) bits. It stops at terminal count.
// TESTING
//  1 Holdoff: release reset, then pulse req1 at cycle 100 with bus_select==bus1 -> no bus_req, no ack1; ready rises at cycle 500.
//  2 Nominal ch1: after ready, rose req1 at T with bus_select==bus1 and bus_done at T+2
//    -> bus_req=1 at T+1..T+2, bus_chan=0, ack1 at T+3 only, ack2=0.
//  3 Timeout ch2: bus_select!=bus1, rose req2 at T, bus_done held 0
//    -> bus_req=1 at T+1..T+5, ack2 and timeout_err at T+6, back to IDLE at T+7.
//  4 Inactive/simultaneous: bus_select==bus1, req1 and req2 rise together -> only channel 1 is served; ack2 never asserts.
//  5 Retarget+overrun: flip bus_select at T+1 and re-rise req1 at T+3
//    -> ack1 still at done+1, overrun_err at T+3, bus_chan stays 0.
//  6 Reset mid-BUSY at T+2 -> outputs 0 at T+3, no ack. Full holdoff is repeated before the next accept.
//  Bench binds SVA: (##HOLDOFF_CYCLES) then always { bus_select==bus1 ? $rose(req1)|=>##[0:ACK_WIN] ack1 : same for ch2 }.

Source files
------------

// File: rtl/dual_bus_req_ack_ctrl_if.sv
// dual_bus_req_ack_ctrl_if: requester, selector and downstream-bus signals of the dual-channel req/ack controller
// master: drives bus_select, bus1, req1, req2, bus_done; observes ack1/2, bus_req, bus_chan, ready, timeout_err, overrun_err
// slave:  the controller side, directions mirrored
interface dual_bus_req_ack_ctrl_if;
  logic bus_select, bus1, req1, req2, bus_done;
  logic ack1, ack2, bus_req, bus_chan, ready, timeout_err, overrun_err;
  modport master (
    output bus_select, bus1, req1, req2, bus_done,
    input  ack1, ack2, bus_req, bus_chan, ready, timeout_err, overrun_err
  );
  modport slave (
    input  bus_select, bus1, req1, req2, bus_done,
    output ack1, ack2, bus_req, bus_chan, ready, timeout_err, overrun_err
  );
endinterface

// File: rtl/dual_bus_req_ack_ctrl.sv
// dual_bus_req_ack_ctrl: serves one of two req/ack channels onto a downstream bus with power-on holdoff and bounded ack latency
// clk, reset (sync, active high); b: slave modport carrying selector, requests, acks, bus handshake, ready and error pulses
module dual_bus_req_ack_ctrl #(
  parameter int HOLDOFF_CYCLES = 500,
  parameter int ACK_WIN = 5
) (
  input logic clk,
  input logic reset,
  dual_bus_req_ack_ctrl_if.slave b
);
  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
  localparam int WW = $clog2(ACK_WIN + 2);
  typedef enum logic [1:0] {HOLD, IDLE, BUSY, DONE} state_t;
  state_t state, state_n;
  logic [HW-1:0] hcnt;
  logic [WW-1:0] wcnt;
  logic req1_q, req2_q, chan, tout, act, rose_act, rose_chan, accept;
  // act/chan: 0 = channel 1, 1 = channel 2
  assign act = b.bus_select != b.bus1;
  assign rose_act = act ? b.req2 & ~req2_q : b.req1 & ~req1_q;
  assign rose_chan = chan ? b.req2 & ~req2_q : b.req1 & ~req1_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= HOLD;
      hcnt <= '0;
      wcnt <= '0;
      req1_q <= 1'b0;
      req2_q <= 1'b0;
      chan <= 1'b0;
      tout <= 1'b0;
    end else begin
      state <= state_n;
      req1_q <= b.req1;
      req2_q <= b.req2;
      if (state == HOLD && hcnt != HW'(HOLDOFF_CYCLES)) hcnt <= hcnt + 1'b1;
      if (accept) begin
        chan <= act;
        wcnt <= '0;
      end else if (state == BUSY && wcnt != '1) wcnt <= wcnt + 1'b1;
      // the value left by the last BUSY cycle says whether DONE was reached by timeout
      if (state == BUSY) tout <= ~b.bus_done;
    end
  end
  always_comb begin
    state_n = state;
    accept = 1'b0;
    case (state)
      HOLD: state_n = hcnt == HW'(HOLDOFF_CYCLES - 1) ? IDLE : HOLD;
      BUSY: state_n = (b.bus_done || wcnt == WW'(ACK_WIN - 1)) ? DONE : BUSY;
      default: begin
        accept = rose_act;
        state_n = rose_act ? BUSY : IDLE;
      end
    endcase
    b.ready = state != HOLD;
    b.bus_req = state == BUSY;
    b.bus_chan = state == BUSY && chan;
    b.ack1 = state == DONE && !chan;
    b.ack2 = state == DONE && chan;
    b.timeout_err = state == DONE && tout;
    b.overrun_err = state == BUSY && rose_chan;
  end
endmodule

// File: tb/tb_dual_bus_req_ack_ctrl.sv
// tb_dual_bus_req_ack_ctrl: vector table, directed corner sequences and random traffic against a timestamp model
module tb_dual_bus_req_ack_ctrl;
  localparam int HOLDOFF = 500;
  localparam int AW = 5;
  localparam logic [6:0] Z = 7'b1000000, B0 = 7'b1100000, B1 = 7'b1110000;
  localparam logic [6:0] A1 = 7'b1001000, A2T = 7'b1000110, B0V = 7'b1100001;
  typedef struct {
    bit s1, r1, r2, d;
    logic [6:0] e;
  } vec_t;
  logic clk = 1'b0, reset = 1'b1;
  int errors = 0, checks = 0;
  bit sva_on = 1'b0;
  int cyc = 0, t_acc = 0, ack_at = -1;
  bit pend = 1'b0, m_chan = 1'b0, to_flag = 1'b0, pq1 = 1'b0, pq2 = 1'b0;
  logic [6:0] obs, expv;
  vec_t tbl[32];
  always #5 clk = ~clk;
  dual_bus_req_ack_ctrl_if bi ();
  dual_bus_req_ack_ctrl #(.HOLDOFF_CYCLES(HOLDOFF), .ACK_WIN(AW)) dut (
    .clk(clk), .reset(reset), .b(bi.slave)
  );
  property p_ack(logic sel, logic req, logic ack);
    @(posedge clk) disable iff (reset || !sva_on || !bi.ready)
      (sel && $rose(req)) |=> ##[0:AW] ack;
  endproperty
  a_ack1: assert property (p_ack(bi.bus_select == bi.bus1, bi.req1, bi.ack1))
    else begin errors++; $display("FAIL sva_ack1 t=%0t: ack1 not within window", $time); end
  a_ack2: assert property (p_ack(bi.bus_select != bi.bus1, bi.req2, bi.ack2))
    else begin errors++; $display("FAIL sva_ack2 t=%0t: ack2 not within window", $time); end
  // obs/expv = {ready, bus_req, bus_chan, ack1, ack2, timeout_err, overrun_err}
  task automatic tick(input bit rst_i, s1, r1, r2, d);
    bit busy, ack, ro1, ro2, act;
    reset = rst_i;
    bi.bus_select = s1 ? bi.bus1 : ~bi.bus1;
    bi.req1 = r1;
    bi.req2 = r2;
    bi.bus_done = d;
    @(negedge clk);
    obs = {bi.ready, bi.bus_req, bi.bus_chan, bi.ack1, bi.ack2, bi.timeout_err, bi.overrun_err};
    if (rst_i) begin
      cyc = 0;
      pend = 1'b0;
      ack_at = -1;
      pq1 = 1'b0;
      pq2 = 1'b0;
    end else begin
      busy = pend && ack_at < 0;
      ack = pend && ack_at == cyc;
      ro1 = r1 && !pq1;
      ro2 = r2 && !pq2;
      act = !s1;
      expv = {cyc >= HOLDOFF, busy, busy && m_chan, ack && !m_chan, ack && m_chan,
              ack && to_flag, busy && (m_chan ? ro2 : ro1)};
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL model cyc=%0d got=%b want=%b", cyc, obs, expv);
      end
      if (busy && (d || cyc == t_acc + AW)) begin
        ack_at = cyc + 1;
        to_flag = !d;
      end else if (cyc >= HOLDOFF && (!pend || ack)) begin
        if (act ? ro2 : ro1) begin
          pend = 1'b1;
          t_acc = cyc;
          m_chan = act;
          ack_at = -1;
        end else pend = 1'b0;
      end
      cyc++;
      pq1 = r1;
      pq2 = r2;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [6:0] got, want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%b want=%b", name, got, want);
    end
  endtask
  initial begin
    bit seen, s1, r1, r2;
    tbl = '{
      '{1,0,0,0,Z}, '{1,1,0,0,Z}, '{1,1,0,0,B0}, '{1,1,0,1,B0}, '{1,0,0,0,A1}, '{1,0,0,0,Z},
      '{0,0,1,0,Z}, '{0,0,1,0,B1}, '{0,0,1,0,B1}, '{0,0,1,0,B1}, '{0,0,1,0,B1}, '{0,0,1,0,B1},
      '{0,0,0,0,A2T}, '{0,0,0,0,Z},
      '{1,1,1,0,Z}, '{1,1,1,1,B0}, '{1,0,0,0,A1}, '{1,0,0,0,Z},
      '{1,1,0,0,Z}, '{0,1,0,0,B0}, '{0,0,0,0,B0}, '{0,1,0,0,B0V}, '{0,1,0,1,B0}, '{0,0,0,0,A1},
      '{0,0,0,0,Z},
      '{1,1,0,0,Z}, '{1,0,0,1,B0}, '{1,1,0,0,A1}, '{1,1,0,1,B0}, '{1,0,0,0,A1},
      '{1,0,0,1,Z}, '{1,0,0,0,Z}
    };
    bi.bus1 = 1'b0;
    for (int i = 0; i < 3; i++) tick(1, 1, 0, 0, 0);
    seen = 1'b0;
    for (int c = 0; c < 520; c++) begin
      tick(0, 1, c == 100, 0, 0);
      if (c == 0) chk("reset_outputs", obs, 7'b0);
      if (c < HOLDOFF) seen |= obs[5] | obs[3];
      if (c == HOLDOFF - 1) chk("ready_before", {6'b0, obs[6]}, 7'b0);
      if (c == HOLDOFF) chk("ready_at_500", {6'b0, obs[6]}, 7'b1);
    end
    chk("holdoff_no_service", {6'b0, seen}, 7'b0);
    sva_on = 1'b1;
    for (int i = 0; i < 32; i++) begin
      tick(0, tbl[i].s1, tbl[i].r1, tbl[i].r2, tbl[i].d);
      chk($sformatf("vec[%0d]", i), obs, tbl[i].e);
    end
    tick(0, 1, 1, 0, 0);
    tick(0, 1, 1, 0, 0);
    chk("busy_before_reset", obs, B0);
    tick(1, 1, 1, 0, 0);
    seen = 1'b0;
    for (int c = 0; c < 510; c++) begin
      tick(0, 1, c == 200 || c >= 505, 0, 0);
      if (c == 0) chk("reset_abort_outputs", obs, 7'b0);
      if (c < HOLDOFF) seen |= obs[5] | obs[3] | obs[2];
      if (c == HOLDOFF) chk("ready_after_rehold", {6'b0, obs[6]}, 7'b1);
      if (c == 506) chk("accept_after_rehold", obs, B0);
    end
    chk("rehold_no_service", {6'b0, seen}, 7'b0);
    sva_on = 1'b0;
    s1 = 1'b1;
    r1 = 1'b1;
    r2 = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) bi.bus1 = ~bi.bus1;
      if ($urandom_range(0, 7) == 0) s1 = ~s1;
      if ($urandom_range(0, 3) == 0) r1 = ~r1;
      if ($urandom_range(0, 3) == 0) r2 = ~r2;
      tick(i == 2000, s1, r1, r2, $urandom_range(0, 3) == 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
